weight_update_scheduler: RTL

Sequencer for the diff-to-decode weight-update pipeline stage. On a start request it walks every weight row of every layer in backprop order, last layer first. For each row it issues one `update_weight` strobe with matching `w_layer_index` / `w_row_index` into the pipeline register. Issue honours a downstream stall. After the last issue it waits for the pipeline to drain, then signals completion.

---
 rtl/weight_update_scheduler.sv | 105 ++++++++++
 1 files changed

// File: rtl/weight_update_scheduler.sv
// rtl/weight_update_scheduler.sv - backprop-order weight-row strobe sequencer with stall, drain and abort
module weight_update_scheduler #(
  parameter int layer_count    = 3,
  parameter int size           = 3,
  parameter int pipeline_depth = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        abort,
  output logic [31:0] w_layer_index,
  output logic [31:0] w_row_index,
  output logic        update_weight,
  output logic        busy,
  output logic        done
);

  localparam int LW = (layer_count > 1) ? $clog2(layer_count) : 1;
  localparam int RW = (size > 1) ? $clog2(size) : 1;
  localparam int CW = $clog2(pipeline_depth + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q;
  logic [LW-1:0]   p_layer_q;
  logic [RW-1:0]   p_row_q;
  logic            exhausted_q;
  logic [LW-1:0]   layer_idx_q;
  logic [RW-1:0]   row_idx_q;
  logic [CW-1:0]   drain_q;
  logic            update_q;
  logic            busy_q;
  logic            done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p_layer_q   <= '0;
      p_row_q     <= '0;
      exhausted_q <= 1'b0;
      layer_idx_q <= '0;
      row_idx_q   <= '0;
      drain_q     <= '0;
      update_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      update_q <= 1'b0;
      done_q   <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q     <= ISSUE;
              busy_q      <= 1'b1;
              p_layer_q   <= LW'(layer_count - 1);
              p_row_q     <= '0;
              exhausted_q <= 1'b0;
            end
          end
          ISSUE: begin
            if (exhausted_q) begin
              // One extra count so done lands pipeline_depth+2 cycles after the last strobe
              state_q <= DRAIN;
              drain_q <= CW'(pipeline_depth);
            end else if (!stall) begin
              update_q    <= 1'b1;
              layer_idx_q <= p_layer_q;
              row_idx_q   <= p_row_q;
              if (p_row_q == RW'(size - 1)) begin
                p_row_q <= '0;
                if (p_layer_q == '0) exhausted_q <= 1'b1;
                else                 p_layer_q   <= p_layer_q - 1'b1;
              end else begin
                p_row_q <= p_row_q + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (drain_q == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              drain_q <= drain_q - 1'b1;
            end
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign w_layer_index = 32'(layer_idx_q);
  assign w_row_index   = 32'(row_idx_q);
  assign update_weight = update_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
